// File: rtl/hba_servo.sv
// HBA slave answering on slot PERIPH_ADDR: four RC-servo PWM outputs whose
// positions are shadowed once per frame, plus a maskable frame-start interrupt.
module hba_servo #(
  parameter int CLK_FREQUENCY     = 60_000_000,
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 6,
  parameter int FRAME_US          = 20000
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  output logic                  hba_xferack_slave,
  output logic                  slave_interrupt,
  output logic [3:0]            servo_pwm
);

  localparam int PRE_DIV = CLK_FREQUENCY / 1_000_000;
  localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int US_W    = $clog2(FRAME_US);
  localparam int CMP_W   = (US_W > 12) ? US_W : 12;

  localparam logic [PRE_W-1:0]          PRE_LAST   = PRE_W'(PRE_DIV - 1);
  localparam logic [US_W-1:0]           US_LAST    = US_W'(FRAME_US - 1);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_CTRL   = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_STATUS = REG_ADDR_WIDTH'(5);

  logic [PRE_W-1:0]             prescale;
  logic [US_W-1:0]              us_count;
  logic [4:0]                   ctrl, ctrl_nxt;
  logic [3:0][7:0]              pos, pos_nxt;
  logic [3:0][7:0]              shadow_pos;
  logic [3:0]                   shadow_en;
  logic                         frame_flag, flag_nxt;

  logic [PERIPH_ADDR_WIDTH-1:0] slot;
  logic [REG_ADDR_WIDTH-1:0]    reg_addr;
  logic                         hit, rd, wr, us_tick, frame_start;
  logic [DBUS_WIDTH-1:0]        rd_data;
  logic [3:0][7:0]              eff_pos;
  logic [3:0]                   eff_en;
  logic [3:0][11:0]             width_n;
  logic [3:0]                   pwm_nxt;

  always_comb begin
    slot        = hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH];
    reg_addr    = hba_abus[REG_ADDR_WIDTH-1:0];
    hit         = hba_select && (slot == PERIPH_ADDR_WIDTH'(PERIPH_ADDR)) && !hba_xferack_slave;
    rd          = hit && hba_rnw;
    wr          = hit && !hba_rnw;
    us_tick     = (prescale == PRE_LAST);
    frame_start = (prescale == '0) && (us_count == '0);

    ctrl_nxt = ctrl;
    pos_nxt  = pos;
    rd_data  = '0;
    if (wr && reg_addr == REG_CTRL)
      ctrl_nxt = hba_dbus[4:0];
    if (reg_addr == REG_CTRL)
      rd_data = DBUS_WIDTH'({3'b000, ctrl});
    if (reg_addr == REG_STATUS)
      rd_data = DBUS_WIDTH'({7'b0000000, frame_flag});
    for (int unsigned i = 0; i < 4; i++) begin
      if (reg_addr == REG_ADDR_WIDTH'(i + 1)) begin
        rd_data = DBUS_WIDTH'(pos[i[1:0]]);
        if (wr)
          pos_nxt[i[1:0]] = hba_dbus[7:0];
      end
    end

    // A set on the frame-start cycle overrides a clearing STATUS read.
    flag_nxt = frame_flag;
    if (rd && reg_addr == REG_STATUS)
      flag_nxt = 1'b0;
    if (frame_start && ctrl[4])
      flag_nxt = 1'b1;

    // On the frame-start cycle the shadows are still being loaded, so the
    // live registers drive the first PWM sample of the new frame.
    for (int unsigned i = 0; i < 4; i++) begin
      eff_pos[i[1:0]] = frame_start ? pos[i[1:0]] : shadow_pos[i[1:0]];
      eff_en[i[1:0]]  = frame_start ? ctrl[i[1:0]] : shadow_en[i[1:0]];
      width_n[i[1:0]] = 12'd1000 + {2'b00, eff_pos[i[1:0]], 2'b00};
      pwm_nxt[i[1:0]] = eff_en[i[1:0]] && (CMP_W'(us_count) < CMP_W'(width_n[i[1:0]]));
    end
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      prescale          <= '0;
      us_count          <= '0;
      ctrl              <= '0;
      pos               <= '0;
      shadow_pos        <= '0;
      shadow_en         <= '0;
      frame_flag        <= 1'b0;
      servo_pwm         <= '0;
      slave_interrupt   <= 1'b0;
      hba_xferack_slave <= 1'b0;
      hba_dbus_slave    <= '0;
    end else begin
      if (us_tick) begin
        prescale <= '0;
        us_count <= (us_count == US_LAST) ? '0 : us_count + 1'b1;
      end else begin
        prescale <= prescale + 1'b1;
      end
      if (frame_start) begin
        shadow_pos <= pos;
        shadow_en  <= ctrl[3:0];
      end
      ctrl              <= ctrl_nxt;
      pos               <= pos_nxt;
      frame_flag        <= flag_nxt;
      servo_pwm         <= pwm_nxt;
      slave_interrupt   <= flag_nxt & ctrl_nxt[4];
      hba_xferack_slave <= hit;
      hba_dbus_slave    <= rd ? rd_data : '0;
    end
  end

endmodule
